alu_mc: RTL and testbench

Parametrised multi-cycle ALU, the next generation of the processor's single-cycle combinational ALU. It adds a configurable datapath width, EOR, ADC and an iterative MUL. It presents registered results and NZVC flags behind a valid/ready handshake, so it can sit in a multi-cycle or pipelined execute stage.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 63 ++++++
 rtl/alu_mc.sv | 172 +++++++++++++++++
 tb/tb_alu_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag indices and FSM encoding for alu_mc.
// Used by the top and by the bench.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_EOR  = 3'b100;
  localparam logic [2:0] ALU_ADC  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle.
// done marks the cycle retiring the last bit; product is the value after it.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  assign done    = run_q && (cnt_q == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/NZVC behind valid/ready.
// Define ALU_MC_MUL_EN to build the iterative multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags,
  output logic             err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_v, op_c;
  logic             op_err, op_mul;
  logic [3:0]       op_flags;

  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             v,
    input logic             c
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

`ifdef ALU_MC_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (src_a),
    .b      (src_b),
    .done   (mul_done),
    .product(mul_prod)
  );
`endif

  always_comb begin
    b_eff = (alu_control == ALU_SUB) ? ~src_b : src_b;
    c_in  = (alu_control == ALU_SUB) ||
            ((alu_control == ALU_ADC) && carry_in);
    sum   = {1'b0, src_a} + {1'b0, b_eff} +
            {{WIDTH{1'b0}}, c_in};
    op_res = '0;
    op_v   = 1'b0;
    op_c   = 1'b0;
    op_err = 1'b0;
    op_mul = 1'b0;
    unique case (alu_control)
      ALU_ADD, ALU_SUB, ALU_ADC: begin
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND: op_res = src_a & src_b;
      ALU_ORR: op_res = src_a | src_b;
      ALU_EOR: op_res = src_a ^ src_b;
`ifdef ALU_MC_MUL_EN
      ALU_MUL: op_mul = 1'b1;
`else
      ALU_MUL: op_err = 1'b1;
`endif
      ALU_RSVD: op_err = 1'b1;
    endcase
    // error results report all-zero flags, not Z=1
    op_flags = op_err ? 4'b0000 : mk_flags(op_res, op_v, op_c);
  end

  assign in_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
`ifdef ALU_MC_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (op_mul) begin
            state_d = ST_BUSY;
`ifdef ALU_MC_MUL_EN
            mul_start = 1'b1;
`endif
          end else begin
            state_d  = ST_DONE;
            result_d = op_res;
            flags_d  = op_flags;
            err_d    = op_err;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef ALU_MC_MUL_EN
        if (mul_done) begin
          state_d  = ST_DONE;
          result_d = mul_prod;
          flags_d  = mk_flags(mul_prod, 1'b0, 1'b0);
          err_d    = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign alu_result = result_q;
  assign alu_flags  = flags_q;
  assign err        = err_q;
`ifdef ALU_MC_MUL_EN
  assign busy = (state_q == ST_BUSY);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vector table plus handshake/reset sequences.
// Expectations for MUL follow whether ALU_MC_MUL_EN is defined.
module tb_alu_mc;
  import alu_pkg::*;

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        err;
  logic        busy;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .err        (err),
    .busy       (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic cin,
    input logic [31:0] res, input logic [3:0] flg,
    input logic e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.res = res; v.flg = flg; v.err = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int lat, busy_n, rdy_bad;
    @(negedge clk);
    alu_control = v.op; src_a = v.a; src_b = v.b;
    carry_in = v.cin; in_valid = 1'b1; out_ready = 1'b0;
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_control = ALU_ADD; carry_in = 1'b1;
    src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
    lat = 0; busy_n = 0; rdy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin
        if (busy) busy_n++;
        if (in_ready) rdy_bad++;
      end
    end while (!out_valid && lat < 100);
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d result", idx), alu_result, v.res);
    check($sformatf("v%0d flags", idx), 32'(alu_flags), 32'(v.flg));
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'(v.lat - 1));
    check($sformatf("v%0d in_ready_busy", idx), 32'(rdy_bad), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int lat;
    vecs[0]  = mkv(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 4'b1010, 0, 1);
    vecs[1]  = mkv(ALU_SUB, 32'd5, 32'd5, 0, 32'h0, 4'b0101, 0, 1);
    vecs[2]  = mkv(ALU_SUB, 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 4'b1000, 0, 1);
    vecs[3]  = mkv(ALU_ADC, 32'hFFFF_FFFF, 32'h0, 1, 32'h0, 4'b0101, 0, 1);
    vecs[4]  = mkv(ALU_EOR, 32'hF0F0, 32'hFFFF, 0, 32'h0F0F, 4'b0000, 0, 1);
    vecs[5]  = mkv(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'h00F0_00F0, 4'b0000, 0, 1);
    vecs[6]  = mkv(ALU_ORR, 32'h8000_0000, 32'h1, 0, 32'h8000_0001, 4'b1000, 0, 1);
    vecs[7]  = mkv(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 4'b0101, 0, 1);
    vecs[8]  = mkv(ALU_SUB, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 4'b0011, 0, 1);
    vecs[9]  = mkv(ALU_ADC, 32'd1, 32'd1, 0, 32'd2, 4'b0000, 0, 1);
    vecs[10] = mkv(ALU_ADD, 32'd0, 32'd0, 0, 32'd0, 4'b0100, 0, 1);
    vecs[11] = mkv(ALU_RSVD, 32'hFFFF, 32'h1, 1, 32'h0, 4'b0000, 1, 1);
    vecs[12] = mkv(ALU_ADD, 32'd1, 32'd1, 1, 32'd2, 4'b0000, 0, 1);
    vecs[13] = mkv(ALU_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 4'b1000, 0, 1);
    vecs[14] = mkv(ALU_MUL, 32'd12, 32'd11, 0, MUL_EN ? 32'd132 : 32'd0,
                   4'b0000, !MUL_EN, MUL_EN ? 33 : 1);
    vecs[15] = mkv(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, MUL_EN ? 32'd1 : 32'd0,
                   4'b0000, !MUL_EN, MUL_EN ? 33 : 1);
    vecs[16] = mkv(ALU_MUL, 32'h1_0000, 32'h1_0000, 0, 32'd0,
                   MUL_EN ? 4'b0100 : 4'b0000, !MUL_EN, MUL_EN ? 33 : 1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = ALU_ADD; src_a = '0; src_b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", alu_result, 32'd0);
    check("rst flags", 32'(alu_flags), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 17; i++) run_op(vecs[i], i);

    // hold result in DONE, then back-to-back accept on release
    @(negedge clk);
    alu_control = ALU_ADD; src_a = 32'd2; src_b = 32'd3;
    carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("hold first_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold result", alu_result, 32'd5);
      check("hold flags", 32'(alu_flags), 32'd0);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    alu_control = ALU_SUB; src_a = 32'd5; src_b = 32'd5;
    #1 check("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b result", alu_result, 32'd0);
    check("b2b flags", 32'(alu_flags), 32'b0101);
    out_ready = 1'b1;

    // reset in the middle of a MUL
    @(negedge clk);
    alu_control = ALU_MUL; src_a = 32'd12; src_b = 32'd11;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst out_valid", 32'(out_valid), 32'd0);
    check("mrst result", alu_result, 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("mrst no_late_valid", 32'(out_valid), 32'd0);
    run_op(mkv(ALU_ADD, 32'd2, 32'd3, 0, 32'd5, 4'b0000, 0, 1), 99);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
